// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, constants and helpers for the data-memory responder
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int ADDR_LSB   = 2;

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word array with byte-enabled write port and registered read port
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_strobe,
    input  logic             i_wr_en,
    input  logic             i_rd_en,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [31:0]      i_wdata,
    input  logic [3:0]       i_be,
    output logic [31:0]      o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;
    logic [31:0] w_mask;

    assign w_mask  = be_mask(i_be);
    assign o_rdata = r_rdata;

    // Contents are deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (i_strobe && i_wr_en) begin
            r_mem[i_idx] <= (r_mem[i_idx] & ~w_mask) | (i_wdata & w_mask);
        end
    end

    // Every access overwrites the read register; non-reads return zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (i_strobe) begin
            r_rdata <= i_rd_en ? r_mem[i_idx] : 32'd0;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - load/store responder with programmable wait states
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0] WAIT_INIT = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t      r_state, w_state_next;
    logic [3:0]  r_cnt, w_cnt_next;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_err;

    logic        w_accept;
    logic        w_access;
    logic        w_acc_we;
    logic [31:0] w_acc_addr;
    logic [31:0] w_acc_wdata;
    logic [3:0]  w_acc_be;
    logic        w_err;
    logic [31:0] w_rdata;

    assign w_accept = req_valid && req_ready;

    // A zero-wait access uses the live request; otherwise the latched copy.
    assign w_acc_we    = (r_state == WAIT) ? r_we    : req_we;
    assign w_acc_addr  = (r_state == WAIT) ? r_addr  : req_addr;
    assign w_acc_wdata = (r_state == WAIT) ? r_wdata : req_wdata;
    assign w_acc_be    = (r_state == WAIT) ? r_be    : req_be;

    assign w_access = !reset &&
                      (((r_state == WAIT) && (r_cnt == 4'd0)) || (ZERO_WAIT && w_accept));

    // Range check on the full word index so out-of-range addresses never alias.
    assign w_err = (w_acc_addr[ADDR_LSB-1:0] != '0) ||
                   ((w_acc_addr >> ADDR_LSB) >= 32'(DEPTH_WORDS));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_access) begin
                r_err <= w_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        req_ready    = 1'b1;
        busy         = 1'b0;
        rsp_valid    = 1'b0;
        case (r_state)
            IDLE, RESP: begin
                rsp_valid = (r_state == RESP);
                if (w_accept) begin
                    w_state_next = ZERO_WAIT ? RESP : WAIT;
                    w_cnt_next   = WAIT_INIT;
                end else begin
                    w_state_next = IDLE;
                end
            end
            WAIT: begin
                req_ready = 1'b0;
                busy      = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_state_next = RESP;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = 4'd0;
            end
        endcase
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .i_strobe (w_access),
        .i_wr_en  (w_acc_we && !w_err),
        .i_rd_en  (!w_acc_we && !w_err),
        .i_idx    (w_acc_addr[ADDR_LSB +: IDX_W]),
        .i_wdata  (w_acc_wdata),
        .i_be     (w_acc_be),
        .o_rdata  (w_rdata)
    );

    assign rsp_rdata = w_rdata;
    assign rsp_err   = r_err;

endmodule
